// File: rtl/merge_feeder_if.sv
// Bundles the two stream push ports and the downstream merger port of merge_feeder.
// master: the feeder itself (accepts pushes, issues to the merger).
// slave : the environment around it (producers and the 2x8 merger).
interface merge_feeder_if;
    // stream A push port
    logic         a_v;
    logic [255:0] a_data;
    logic         a_rdy;
    // stream B push port
    logic         b_v;
    logic [255:0] b_data;
    logic         b_rdy;
    // merger port
    logic         m_v;
    logic [255:0] m8A;
    logic [255:0] m8B;
    logic [4:0]   m_rd;
    logic         m_next_source_v;
    logic         m_next_source;
    logic         m_not_accepting;

    modport master (
        input  a_v, a_data, b_v, b_data,
        output a_rdy, b_rdy,
        output m_v, m8A, m8B, m_rd,
        input  m_next_source_v, m_next_source, m_not_accepting
    );

    modport slave (
        output a_v, a_data, b_v, b_data,
        input  a_rdy, b_rdy,
        input  m_v, m8A, m8B, m_rd,
        output m_next_source_v, m_next_source, m_not_accepting
    );
endinterface

// File: rtl/merge_feeder.sv
// Feeds two buffered streams of sorted 8x32 vectors into a downstream 2x8 merger.
// Each stream has its own FIFO; an exhausted stream presents the all-ones sentinel.
// One issue per merger handshake, lenA+lenB issues per run, last issue tagged rd=0.
module merge_feeder #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [4:0]  RUN_RD     = 5'd1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] lenA,
    input  logic [7:0] lenB,
    output logic       busy,
    output logic       done,
    merge_feeder_if.master bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [255:0] SENTINEL = '1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_SEL, WAIT_ACC} state_t;
    state_t state, state_nx;

    // stream FIFOs: pointers carry one extra wrap bit to tell full from empty
    logic [255:0] mem_a [FIFO_DEPTH];
    logic [255:0] mem_b [FIFO_DEPTH];
    logic [AW:0]  wp_a, rp_a, wp_b, rp_b;
    logic         empty_a, empty_b, full_a, full_b;
    logic         push_a, push_b, deq_a, deq_b;
    logic [255:0] head_a, head_b;

    // run bookkeeping
    logic [7:0]   len_a_q, len_b_q;
    logic [8:0]   cnt_a, cnt_b, issue_cnt;
    logic [8:0]   total, start_total;
    logic         first_q;
    logic         exh_a, exh_b;

    // FSM control strobes
    logic         load_run, fire, pop_a, pop_b, clr_first, done_set;

    assign empty_a = (wp_a == rp_a);
    assign empty_b = (wp_b == rp_b);
    assign full_a  = (wp_a[AW] != rp_a[AW]) && (wp_a[AW-1:0] == rp_a[AW-1:0]);
    assign full_b  = (wp_b[AW] != rp_b[AW]) && (wp_b[AW-1:0] == rp_b[AW-1:0]);

    assign bus.a_rdy = !full_a;
    assign bus.b_rdy = !full_b;
    assign push_a    = bus.a_v && !full_a;
    assign push_b    = bus.b_v && !full_b;
    // a pop request only dequeues real data; exhausted streams never request one
    assign deq_a     = pop_a && !empty_a;
    assign deq_b     = pop_b && !empty_b;

    assign head_a = mem_a[rp_a[AW-1:0]];
    assign head_b = mem_b[rp_b[AW-1:0]];

    assign total       = {1'b0, len_a_q} + {1'b0, len_b_q};
    assign start_total = {1'b0, lenA} + {1'b0, lenB};
    assign exh_a       = (cnt_a == {1'b0, len_a_q});
    assign exh_b       = (cnt_b == {1'b0, len_b_q});

    assign busy    = (state != IDLE);
    assign bus.m_v = fire;
    assign bus.m8A = exh_a ? SENTINEL : head_a;
    assign bus.m8B = exh_b ? SENTINEL : head_b;
    // the final issue of a run carries rd=0 so the merger drops its retained half
    assign bus.m_rd = !fire ? '0 :
                      ((issue_cnt + 9'd1) == total) ? '0 : RUN_RD;

    // FIFO storage writes; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (push_a) mem_a[wp_a[AW-1:0]] <= bus.a_data;
        if (push_b) mem_b[wp_b[AW-1:0]] <= bus.b_data;
    end

    // FIFO pointer update; push and pop in one cycle both take effect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_a <= '0;
            rp_a <= '0;
            wp_b <= '0;
            rp_b <= '0;
        end else begin
            if (push_a) wp_a <= wp_a + (AW+1)'(1);
            if (deq_a)  rp_a <= rp_a + (AW+1)'(1);
            if (push_b) wp_b <= wp_b + (AW+1)'(1);
            if (deq_b)  rp_b <= rp_b + (AW+1)'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // run length latch, consumed/issue counters, first-issue flag and done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_a_q   <= '0;
            len_b_q   <= '0;
            cnt_a     <= '0;
            cnt_b     <= '0;
            issue_cnt <= '0;
            first_q   <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= done_set;
            if (load_run) begin
                len_a_q   <= lenA;
                len_b_q   <= lenB;
                cnt_a     <= '0;
                cnt_b     <= '0;
                issue_cnt <= '0;
                first_q   <= 1'b1;
            end else begin
                if (fire)      issue_cnt <= issue_cnt + 9'd1;
                if (pop_a)     cnt_a     <= cnt_a + 9'd1;
                if (pop_b)     cnt_b     <= cnt_b + 9'd1;
                if (clr_first) first_q   <= 1'b0;
            end
        end
    end

    // next-state and control strobes
    always_comb begin
        state_nx  = state;
        load_run  = 1'b0;
        fire      = 1'b0;
        pop_a     = 1'b0;
        pop_b     = 1'b0;
        clr_first = 1'b0;
        done_set  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load_run = 1'b1;
                    if (start_total == '0) done_set = 1'b1;
                    else                   state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (!bus.m_not_accepting && (!empty_a || exh_a) && (!empty_b || exh_b)) begin
                    fire     = 1'b1;
                    state_nx = WAIT_SEL;
                end
            end
            WAIT_SEL: begin
                if (bus.m_next_source_v) begin
                    if (first_q) begin
                        // the first issue loads both heads into the merger
                        pop_a     = !exh_a;
                        pop_b     = !exh_b;
                        clr_first = 1'b1;
                    end else begin
                        pop_a = !bus.m_next_source && !exh_a;
                        pop_b =  bus.m_next_source && !exh_b;
                    end
                    state_nx = WAIT_ACC;
                end
            end
            WAIT_ACC: begin
                if (!bus.m_not_accepting) begin
                    if (issue_cnt == total) begin
                        done_set = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        state_nx = ISSUE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_merge_feeder.sv
// Scoreboard bench for merge_feeder: directed runs push hand-computed issue records,
// a monitor pops and compares on every m_v, and a behavioural 2x8 merger answers.
module tb_merge_feeder;
    localparam logic [255:0] ONES = '1;

    typedef struct {
        logic [255:0] a;
        logic [255:0] b;
        logic [4:0]   rd;
    } iss_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] lenA, lenB;
    logic       busy, done;

    merge_feeder_if bus();

    merge_feeder #(.FIFO_DEPTH(4), .RUN_RD(5'd1)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .lenA  (lenA),
        .lenB  (lenB),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           done_cnt = 0;
    int           iss_cnt  = 0;
    int           run_d0   = 0;
    int unsigned  acc_hold = 2;
    iss_t         exp_q[$];
    logic [255:0] exp_out[$];
    logic [255:0] out_q[$];
    logic         mg_first = 1'b1;
    logic [255:0] mg_keep  = '1;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] mkvec(input int unsigned base, input int unsigned step);
        logic [255:0] v;
        for (int unsigned k = 0; k < 8; k++) v[32*k +: 32] = 32'(base + k*step);
        return v;
    endfunction

    function automatic void merge16(input logic [255:0] x, input logic [255:0] y,
                                    output logic [255:0] lo, output logic [255:0] hi);
        logic [31:0] e[16];
        logic [31:0] t;
        for (int unsigned i = 0; i < 8; i++) begin
            e[i]   = x[32*i +: 32];
            e[8+i] = y[32*i +: 32];
        end
        for (int unsigned i = 0; i < 16; i++)
            for (int unsigned j = 0; j < 15 - i; j++)
                if (e[j] > e[j+1]) begin
                    t = e[j]; e[j] = e[j+1]; e[j+1] = t;
                end
        for (int unsigned i = 0; i < 8; i++) begin
            lo[32*i +: 32] = e[i];
            hi[32*i +: 32] = e[8+i];
        end
    endfunction

    task automatic exp_issue(input logic [255:0] a, input logic [255:0] b, input logic [4:0] rd);
        iss_t e;
        e.a = a; e.b = b; e.rd = rd;
        exp_q.push_back(e);
    endtask

    task automatic push(input int unsigned s, input logic [255:0] v);
        int unsigned t = 0;
        @(negedge clk);
        if (s == 0) begin bus.a_v = 1'b1; bus.a_data = v; end
        else        begin bus.b_v = 1'b1; bus.b_data = v; end
        while (((s == 0) ? !bus.a_rdy : !bus.b_rdy) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if ((s == 0) ? !bus.a_rdy : !bus.b_rdy) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: stream %0d rdy=0 after %0d cycles, required 1", s, t);
        end
        @(negedge clk);
        bus.a_v = 1'b0;
        bus.b_v = 1'b0;
    endtask

    task automatic start_pulse(input logic [7:0] la, input logic [7:0] lb);
        @(negedge clk);
        run_d0 = done_cnt;
        start  = 1'b1;
        lenA   = la;
        lenB   = lb;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic finish_run(input string nm);
        int unsigned t = 0;
        while (done_cnt == run_d0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        chk({nm, "_done_count"}, done_cnt - run_d0, 1);
        chk({nm, "_issues_left"}, exp_q.size(), 0);
        chk({nm, "_out_count"}, out_q.size(), exp_out.size());
        while (exp_out.size() > 0 && out_q.size() > 0)
            chk({nm, "_merged"}, out_q.pop_front(), exp_out.pop_front());
        exp_q.delete();
        out_q.delete();
        exp_out.delete();
    endtask

    // monitor: compare every issue against the scoreboard, count done pulses
    initial begin : monitor
        iss_t e;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (bus.m_v) begin
                iss_cnt++;
                chk("issue_while_not_accepting", bus.m_not_accepting, 0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_issue: m_v=1 got, m_v=0 required (A=%h)", bus.m8A);
                end else begin
                    e = exp_q.pop_front();
                    chk("issue_m8A", bus.m8A, e.a);
                    chk("issue_m8B", bus.m8B, e.b);
                    chk("issue_m_rd", bus.m_rd, e.rd);
                end
            end
        end
    end

    // behavioural 2x8 merger: emits the lower 8 values, retains the upper 8
    initial begin : merger_model
        logic [255:0] va, vb, lo, hi, pick;
        logic         src;
        logic [4:0]   rd;
        bus.m_next_source_v = 1'b0;
        bus.m_next_source   = 1'b0;
        bus.m_not_accepting = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.m_v && !reset) begin
                va = bus.m8A;
                vb = bus.m8B;
                rd = bus.m_rd;
                if (mg_first) begin
                    src = 1'b0;
                    merge16(va, vb, lo, hi);
                end else begin
                    src  = (vb[31:0] < va[31:0]);
                    pick = src ? vb : va;
                    merge16(mg_keep, pick, lo, hi);
                end
                mg_keep  = hi;
                mg_first = (rd == 5'd0);
                out_q.push_back(lo);
                @(negedge clk);
                bus.m_not_accepting = 1'b1;
                @(negedge clk);
                bus.m_next_source_v = 1'b1;
                bus.m_next_source   = src;
                @(negedge clk);
                bus.m_next_source_v = 1'b0;
                repeat (acc_hold) @(negedge clk);
                bus.m_not_accepting = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int base;
        int unsigned t;
        reset = 1'b1; start = 1'b0; lenA = '0; lenB = '0;
        bus.a_v = 1'b0; bus.a_data = '0; bus.b_v = 1'b0; bus.b_data = '0;

        // reset state
        #2;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_m_v", bus.m_v, 0);
        chk("reset_m_rd", bus.m_rd, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_a_rdy", bus.a_rdy, 1);
        chk("reset_b_rdy", bus.b_rdy, 1);

        // zero-length run: done next cycle, no issue
        base = iss_cnt;
        start_pulse(8'd0, 8'd0);
        chk("zero_len_done", done, 1);
        chk("zero_len_busy", busy, 0);
        @(negedge clk);
        chk("zero_len_done_single", done, 0);
        chk("zero_len_no_issue", iss_cnt, base);

        // basic run
        push(0, mkvec(1, 1));
        push(1, mkvec(9, 1));
        exp_issue(mkvec(1, 1), mkvec(9, 1), 5'd1);
        exp_issue(ONES, ONES, 5'd0);
        exp_out.push_back(mkvec(1, 1));
        exp_out.push_back(mkvec(9, 1));
        start_pulse(8'd1, 8'd1);
        finish_run("basic");

        // interleaved run, with a start while busy that must be ignored
        push(0, mkvec(1, 2));  push(0, mkvec(17, 1)); push(0, mkvec(26, 2));
        push(1, mkvec(2, 2));  push(1, mkvec(25, 2));
        exp_issue(mkvec(1, 2),  mkvec(2, 2),  5'd1);
        exp_issue(mkvec(17, 1), mkvec(25, 2), 5'd1);
        exp_issue(mkvec(26, 2), mkvec(25, 2), 5'd1);
        exp_issue(mkvec(26, 2), ONES,         5'd1);
        exp_issue(ONES,         ONES,         5'd0);
        for (int unsigned i = 0; i < 5; i++) exp_out.push_back(mkvec(1 + 8*i, 1));
        start_pulse(8'd3, 8'd2);
        repeat (3) @(negedge clk);
        chk("interleave_busy", busy, 1);
        start = 1'b1; lenA = 8'd1; lenB = 8'd1;
        @(negedge clk);
        start = 1'b0;
        finish_run("interleave");

        // empty stream B
        push(0, mkvec(100, 1));
        push(0, mkvec(200, 3));
        exp_issue(mkvec(100, 1), ONES, 5'd1);
        exp_issue(mkvec(200, 3), ONES, 5'd0);
        exp_out.push_back(mkvec(100, 1));
        exp_out.push_back(mkvec(200, 3));
        start_pulse(8'd2, 8'd0);
        finish_run("empty_b");

        // backpressure: B starved in ISSUE, merger holds not_accepting for 10 cycles
        acc_hold = 10;
        push(0, mkvec(1, 1));
        push(0, mkvec(20, 1));
        exp_issue(mkvec(1, 1),  mkvec(9, 1), 5'd1);
        exp_issue(mkvec(20, 1), ONES,        5'd1);
        exp_issue(ONES,         ONES,        5'd0);
        exp_out.push_back(mkvec(1, 1));
        exp_out.push_back(mkvec(9, 1));
        exp_out.push_back(mkvec(20, 1));
        base = iss_cnt;
        start_pulse(8'd2, 8'd1);
        repeat (8) @(negedge clk);
        chk("starved_no_issue", iss_cnt, base);
        chk("starved_busy", busy, 1);
        push(1, mkvec(9, 1));
        finish_run("backpressure");
        acc_hold = 2;

        // FIFO full boundary and a push held while a_rdy=0
        for (int unsigned i = 0; i < 4; i++) push(0, mkvec(100*(i+1), 1));
        chk("full_a_rdy", bus.a_rdy, 0);
        chk("full_b_rdy", bus.b_rdy, 1);
        for (int unsigned i = 0; i < 5; i++) begin
            exp_issue(mkvec(100*(i+1), 1), ONES, (i == 4) ? 5'd0 : 5'd1);
            exp_out.push_back(mkvec(100*(i+1), 1));
        end
        start_pulse(8'd5, 8'd0);
        push(0, mkvec(500, 1));
        finish_run("fifo_full");

        // reset on the cycle after an issue abandons the run
        push(0, mkvec(1, 2)); push(0, mkvec(17, 1));
        push(1, mkvec(2, 2)); push(1, mkvec(25, 1));
        exp_issue(mkvec(1, 2), mkvec(2, 2), 5'd1);
        base = iss_cnt;
        start_pulse(8'd2, 8'd2);
        t = 0;
        while (iss_cnt == base && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("pre_reset_issue", iss_cnt - base, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_reset_m_v", bus.m_v, 0);
        chk("mid_reset_busy", busy, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        out_q.delete();
        base = iss_cnt;
        repeat (20) @(negedge clk);
        mg_first = 1'b1;
        chk("post_reset_no_issue", iss_cnt, base);
        chk("post_reset_busy", busy, 0);
        chk("post_reset_a_rdy", bus.a_rdy, 1);
        chk("post_reset_b_rdy", bus.b_rdy, 1);

        // fresh run after reset
        push(0, mkvec(1, 1));
        push(1, mkvec(9, 1));
        exp_issue(mkvec(1, 1), mkvec(9, 1), 5'd1);
        exp_issue(ONES, ONES, 5'd0);
        exp_out.push_back(mkvec(1, 1));
        exp_out.push_back(mkvec(9, 1));
        start_pulse(8'd1, 8'd1);
        finish_run("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
